// File: rtl/baud_cfg_ctrl.sv
// Baud generator configuration sequencer: shadows divisor/mode writes and, on commit,
// quiesces the UART, aligns to a bclk boundary and restarts the generator cleanly.
module baud_cfg_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'd31250,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  input  logic        uart_busy,
  input  logic        bclk,
  output logic [15:0] dlh_dll,
  output logic        mode_osl,
  output logic        baud_rstn,
  output logic        tx_hold,
  output logic        cfg_done
);

  localparam int unsigned TMO_W = 16;
  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] ADDR_DLL    = 2'd0;
  localparam logic [1:0] ADDR_DLH    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LINE = 3'd1,
    S_DRAIN     = 3'd2,
    S_APPLY     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [15:0]      shadow_div;
  logic             shadow_mode;
  logic             err_timeout;
  logic             wr_drop;
  logic             err_zero;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RST_W-1:0] rst_cnt;

  logic             wr_cfg;
  logic             commit_req;
  logic             commit_go;
  logic             zero_hit;
  logic             drop_hit;
  logic             tmo_hit;
  logic             timeout_hit;
  logic             rst_last;
  logic             load_cfg;
  logic             tx_hold_nxt;
  logic             baud_rstn_nxt;
  logic             cfg_done_nxt;
  logic [7:0]       status_val;
  logic [7:0]       rd_mux;

  // Decode of register-interface events
  assign wr_cfg      = wr_en && (addr != ADDR_STATUS);
  assign commit_req  = wr_en && (addr == ADDR_CTRL) && wr_data[7] && (state == S_IDLE);
  assign zero_hit    = commit_req && (shadow_div == 16'd0);
  assign commit_go   = commit_req && (shadow_div != 16'd0);
  assign drop_hit    = wr_cfg && (state != S_IDLE);
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign timeout_hit = (state == S_WAIT_LINE) && uart_busy && tmo_hit;
  assign rst_last    = (rst_cnt == RST_W'(RST_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; line idle wins over a timeout landing on the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (commit_go) state_nxt = S_WAIT_LINE;
      end
      S_WAIT_LINE: begin
        if (!uart_busy)   state_nxt = S_DRAIN;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (bclk) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        if (rst_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    tx_hold_nxt   = 1'b0;
    baud_rstn_nxt = 1'b1;
    cfg_done_nxt  = 1'b0;
    load_cfg      = 1'b0;
    tx_hold_nxt   = (state_nxt != S_IDLE);
    baud_rstn_nxt = (state_nxt != S_APPLY);
    cfg_done_nxt  = (state_nxt == S_DONE);
    load_cfg      = (state == S_DRAIN) && (state_nxt == S_APPLY);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dlh_dll   <= DEFAULT_DIV;
      mode_osl  <= 1'b0;
      baud_rstn <= 1'b0;
      tx_hold   <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      baud_rstn <= baud_rstn_nxt;
      tx_hold   <= tx_hold_nxt;
      cfg_done  <= cfg_done_nxt;
      if (load_cfg) begin
        dlh_dll  <= shadow_div;
        mode_osl <= shadow_mode;
      end
    end
  end

  // Line-idle timeout and reset-pulse counters, held at zero outside their states
  always_ff @(posedge clk) begin
    if (!rstn || (state != S_WAIT_LINE)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || (state != S_APPLY)) begin
      rst_cnt <= '0;
    end else begin
      rst_cnt <= rst_cnt + RST_W'(1);
    end
  end

  assign status_val = {4'b0000, err_zero, wr_drop, err_timeout, (state != S_IDLE)};

  // Read mux; commit bit is write-only
  always_comb begin
    rd_mux = 8'd0;
    case (addr)
      ADDR_DLL:    rd_mux = shadow_div[7:0];
      ADDR_DLH:    rd_mux = shadow_div[15:8];
      ADDR_CTRL:   rd_mux = {7'd0, shadow_mode};
      ADDR_STATUS: rd_mux = status_val;
      default:     rd_mux = 8'd0;
    endcase
  end

  // Shadow registers, sticky status (set beats clear) and read data
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow_div  <= DEFAULT_DIV;
      shadow_mode <= 1'b0;
      err_timeout <= 1'b0;
      wr_drop     <= 1'b0;
      err_zero    <= 1'b0;
      rd_data     <= 8'd0;
    end else begin
      if (wr_en && (state == S_IDLE)) begin
        case (addr)
          ADDR_DLL:  shadow_div[7:0]  <= wr_data;
          ADDR_DLH:  shadow_div[15:8] <= wr_data;
          ADDR_CTRL: shadow_mode      <= wr_data[0];
          default:   ;
        endcase
      end
      if (wr_en && (addr == ADDR_STATUS)) begin
        if (wr_data[1]) err_timeout <= 1'b0;
        if (wr_data[2]) wr_drop     <= 1'b0;
        if (wr_data[3]) err_zero    <= 1'b0;
      end
      if (timeout_hit) err_timeout <= 1'b1;
      if (drop_hit)    wr_drop     <= 1'b1;
      if (zero_hit)    err_zero    <= 1'b1;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Scoreboard bench for baud_cfg_ctrl: stimulus queues expected reads and config
// completions; a monitor pops and compares as the DUT presents them.
module tb_baud_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        uart_busy;
  logic        bclk;
  logic [15:0] dlh_dll;
  logic        mode_osl;
  logic        baud_rstn;
  logic        tx_hold;
  logic        cfg_done;

  logic        bclk_en    = 1'b0;
  logic        bclk_force = 1'b0;
  logic [2:0]  bph        = 3'd0;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rd_q[$];
  string       rd_name_q[$];
  logic [16:0] done_q[$];

  logic rd_pend  = 1'b0;
  int   low_len  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) bph <= bph + 3'd1;
  assign bclk = bclk_en ? (bph == 3'd7) : bclk_force;

  baud_cfg_ctrl #(
    .DEFAULT_DIV(16'd31250),
    .RST_CYCLES (2),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .uart_busy(uart_busy),
    .bclk     (bclk),
    .dlh_dll  (dlh_dll),
    .mode_osl (mode_osl),
    .baud_rstn(baud_rstn),
    .tx_hold  (tx_hold),
    .cfg_done (cfg_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (tx_hold && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(tx_hold), 32'd0);
  endtask

  // Monitor: read data returns the cycle after rd_en; cfg_done carries the new config
  always @(posedge clk) rd_pend <= rd_en;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got 0x%0h with nothing queued", rd_data);
      end else begin
        logic [7:0] e;
        string nm;
        e  = rd_q.pop_front();
        nm = rd_name_q.pop_front();
        chk(nm, 32'(rd_data), 32'(e));
      end
    end
    if (cfg_done) begin
      if (done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL done_unexpected: got cfg_done with div 0x%0h", dlh_dll);
      end else begin
        logic [16:0] e;
        e = done_q.pop_front();
        chk("done_div",  32'(dlh_dll),  32'(e[15:0]));
        chk("done_mode", 32'(mode_osl), 32'(e[16]));
        chk("rst_low_len", 32'(low_len), 32'd2);
      end
      low_len = 0;
    end else if (!baud_rstn) begin
      low_len++;
    end else begin
      low_len = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = 8'd0; uart_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // T1 reset values
    chk("rst_div",      32'(dlh_dll),   32'h7A12);
    chk("rst_mode",     32'(mode_osl),  32'd0);
    chk("rst_baud_rstn",32'(baud_rstn), 32'd0);
    chk("rst_tx_hold",  32'(tx_hold),   32'd0);
    chk("rst_cfg_done", 32'(cfg_done),  32'd0);
    chk("rst_rd_data",  32'(rd_data),   32'd0);
    rstn = 1'b1;
    tick();
    chk("rel_baud_rstn", 32'(baud_rstn), 32'd1);
    rd(2'd3, 8'h00, "rst_status");
    rd(2'd0, 8'h12, "rst_dll");
    rd(2'd1, 8'h7A, "rst_dlh");
    rd(2'd2, 8'h00, "rst_ctrl");

    // T2 normal commit
    bclk_en = 1'b1;
    wr(2'd0, 8'h10);
    wr(2'd1, 8'h00);
    rd(2'd0, 8'h10, "t2_dll");
    done_q.push_back({1'b1, 16'h0010});
    wr(2'd2, 8'h81);
    chk("t2_tx_hold", 32'(tx_hold), 32'd1);
    rd(2'd3, 8'h01, "t2_status_busy");
    wait_idle(100, "t2_idle");
    chk("t2_div", 32'(dlh_dll), 32'h0010);
    rd(2'd2, 8'h01, "t2_ctrl");
    rd(2'd3, 8'h00, "t2_status");

    // T3 busy line, then release
    uart_busy = 1'b1;
    wr(2'd0, 8'h20);
    done_q.push_back({1'b0, 16'h0020});
    wr(2'd2, 8'h80);
    repeat (40) tick();
    chk("t3_hold_busy", 32'(tx_hold), 32'd1);
    rd(2'd3, 8'h01, "t3_status_wait");
    uart_busy = 1'b0;
    wait_idle(100, "t3_idle");

    // T3 timeout leaves active config untouched
    uart_busy = 1'b1;
    wr(2'd0, 8'h40);
    wr(2'd2, 8'h81);
    repeat (60) tick();
    chk("t3_tmo_hold", 32'(tx_hold),  32'd0);
    chk("t3_tmo_div",  32'(dlh_dll),  32'h0020);
    chk("t3_tmo_mode", 32'(mode_osl), 32'd0);
    rd(2'd3, 8'h02, "t3_tmo_status");
    uart_busy = 1'b0;
    wr(2'd3, 8'h02);
    rd(2'd3, 8'h00, "t3_tmo_clear");
    rd(2'd0, 8'h40, "t3_shadow");

    // T4 zero divisor
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h81);
    chk("t4_no_hold", 32'(tx_hold), 32'd0);
    rd(2'd3, 8'h08, "t4_status");
    chk("t4_div", 32'(dlh_dll), 32'h0020);
    rd(2'd2, 8'h01, "t4_ctrl");
    rd_q.push_back(8'h08);
    rd_name_q.push_back("t4_rdwr_preclear");
    rd_en = 1'b1; wr_en = 1'b1; addr = 2'd3; wr_data = 8'h08;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    rd(2'd3, 8'h00, "t4_cleared");

    // T5 write dropped in DRAIN, then reset during APPLY
    bclk_en = 1'b0; bclk_force = 1'b0;
    wr(2'd0, 8'h08);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h80);
    tick();
    wr(2'd0, 8'h55);
    rd(2'd3, 8'h05, "t5_status_drop");
    rd(2'd0, 8'h08, "t5_shadow_kept");
    chk("t5_drain_hold", 32'(tx_hold), 32'd1);
    bclk_force = 1'b1;
    tick();
    bclk_force = 1'b0;
    chk("t5_apply_div",  32'(dlh_dll),   32'h0008);
    chk("t5_apply_rstn", 32'(baud_rstn), 32'd0);
    rstn = 1'b0;
    tick();
    chk("t5_rst_div",  32'(dlh_dll),  32'h7A12);
    chk("t5_rst_hold", 32'(tx_hold),  32'd0);
    chk("t5_rst_done", 32'(cfg_done), 32'd0);
    rstn = 1'b1;
    tick();
    rd(2'd3, 8'h00, "t5_status_after_rst");
    rd(2'd0, 8'h12, "t5_dll_after_rst");

    // Full 16-bit divisor with mode write ahead of commit
    bclk_en = 1'b1;
    wr(2'd0, 8'h34);
    wr(2'd1, 8'h12);
    wr(2'd2, 8'h01);
    rd(2'd2, 8'h01, "t6_ctrl");
    rd(2'd1, 8'h12, "t6_dlh");
    done_q.push_back({1'b1, 16'h1234});
    wr(2'd2, 8'h81);
    wait_idle(100, "t6_idle");
    chk("t6_div",  32'(dlh_dll),  32'h1234);
    chk("t6_mode", 32'(mode_osl), 32'd1);
    rd(2'd3, 8'h00, "t6_status");

    repeat (4) tick();
    chk("rd_q_drained",   32'(rd_q.size()),   32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
